// File: rtl/mathb_tpram_seq.sv
// mathb_tpram_seq: TPRAM read sequencer driving MATH_BLOCK MAC for dot-product/FIR passes
module mathb_tpram_seq #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              EFPGA2MATHB_CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] oper_base,
  input  logic [ADDR_W-1:0] coef_base,
  input  logic [CNT_W-1:0]  coef_len,
  input  logic [CNT_W-1:0]  length,
  output logic              MATHB_TPRAM_OPER_R_EN,
  output logic [ADDR_W-1:0] MATHB_TPRAM_OPER_R_ADDR,
  output logic              MATHB_TPRAM_COEF_R_EN,
  output logic [ADDR_W-1:0] MATHB_TPRAM_COEF_R_ADDR,
  output logic              EFPGA_MATHB_CLK_EN,
  output logic              EFPGA_MATHB_MAC_ACC_CLEAR,
  input  logic [31:0]       FMATHB_EFPGA_MAC_OUT,
  output logic [31:0]       result,
  output logic              done,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] oper_base_q, coef_base_q, oper_last_q, coef_last_q, oper_addr, coef_addr;
  logic [CNT_W-1:0]  len_q, clen_q, beat_q, cidx_q;
  logic [31:0]       result_q;
  logic              en_q, clr_q, accept, fetch, drain, last_beat, drain_end;
  assign accept    = state_q == IDLE && start && !abort;
  assign fetch     = state_q == FETCH && !abort;
  assign drain     = state_q == DRAIN && !abort;
  assign last_beat = beat_q == len_q - CNT_W'(1);
  assign drain_end = beat_q == CNT_W'(2);
  assign oper_addr = oper_base_q + ADDR_W'(beat_q);
  assign coef_addr = coef_base_q + ADDR_W'(cidx_q);
  // Addresses hold the last issued read once R_EN drops
  assign MATHB_TPRAM_OPER_R_EN     = fetch;
  assign MATHB_TPRAM_COEF_R_EN     = fetch;
  assign MATHB_TPRAM_OPER_R_ADDR   = fetch ? oper_addr : oper_last_q;
  assign MATHB_TPRAM_COEF_R_ADDR   = fetch ? coef_addr : coef_last_q;
  assign EFPGA_MATHB_CLK_EN        = en_q && !abort;
  assign EFPGA_MATHB_MAC_ACC_CLEAR = clr_q && !abort;
  assign done                      = state_q == DONE && !abort;
  assign busy                      = state_q != IDLE;
  assign result                    = result_q;
  always_comb
    state_d = abort            ? IDLE :
              state_q == IDLE  ? (start ? (length == '0 ? DONE : FETCH) : IDLE) :
              state_q == FETCH ? (last_beat ? DRAIN : FETCH) :
              state_q == DRAIN ? (drain_end ? DONE : DRAIN) : IDLE;
  always_ff @(posedge EFPGA2MATHB_CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      oper_base_q <= '0;
      coef_base_q <= '0;
      oper_last_q <= '0;
      coef_last_q <= '0;
      len_q       <= '0;
      clen_q      <= '0;
      beat_q      <= '0;
      cidx_q      <= '0;
      result_q    <= '0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= fetch;
      clr_q   <= fetch && beat_q == '0;
      if (accept) begin
        oper_base_q <= oper_base;
        coef_base_q <= coef_base;
        len_q       <= length;
        clen_q      <= coef_len;
        beat_q      <= '0;
        cidx_q      <= '0;
        if (length == '0) result_q <= '0;
      end
      if (fetch) begin
        oper_last_q <= oper_addr;
        coef_last_q <= coef_addr;
        beat_q      <= last_beat ? '0 : beat_q + CNT_W'(1);
        cidx_q      <= (clen_q != '0 && cidx_q + CNT_W'(1) == clen_q) ? '0 : cidx_q + CNT_W'(1);
      end
      // beat_q doubles as the drain cycle counter
      if (drain) begin
        beat_q <= beat_q + CNT_W'(1);
        if (drain_end) result_q <= FMATHB_EFPGA_MAC_OUT;
      end
    end
  end
endmodule

// File: doc/mathb_tpram_seq.md
# mathb_tpram_seq

Read-side sequencer that feeds MATH_BLOCK from the two TPRAMs for a dot-product / FIR tap pass. On `start` it issues `length` paired operand/coefficient reads, pipelines the MAC clock enable and accumulator clear to match TPRAM read latency, and captures the registered MAC output into `result` with a one-cycle `done` pulse. It sits between eFPGA control logic and the TPRAM read ports; MATH_BLOCK is configured with OPER/COEF defPin = 2'b10 (TPRAM source).

## Interface
- ADDR_W, 10, TPRAM read address width (operand and coefficient).
- CNT_W, 10, width of `length` / `coef_len`.

- EFPGA2MATHB_CLK  in  1  single clock, shared with MATH_BLOCK.
- reset  in  1  synchronous, active-high.
- start  in  1  begin pass; sampled only in IDLE.
- abort  in  1  cancel pass; wins over start.
- oper_base  in  ADDR_W  first operand address.
- coef_base  in  ADDR_W  first coefficient address.
- coef_len  in  CNT_W  coefficient ring length; 0 = no wrap.
- length  in  CNT_W  number of operand/coef pairs; 0 = empty pass.
- MATHB_TPRAM_OPER_R_EN / MATHB_TPRAM_OPER_R_ADDR  out  1 / ADDR_W  operand read.
- MATHB_TPRAM_COEF_R_EN / MATHB_TPRAM_COEF_R_ADDR  out  1 / ADDR_W  coefficient read.
- EFPGA_MATHB_CLK_EN  out  1  MAC accumulate enable.
- EFPGA_MATHB_MAC_ACC_CLEAR  out  1  load-not-add on first beat.
- FMATHB_EFPGA_MAC_OUT  in  32  registered MAC output.
- result  out  32  captured MAC result.
- done  out  1  one-cycle pulse, result valid.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- Inputs `oper_base`, `coef_base`, `coef_len`, `length` latched on accepted start; later changes ignored.
- IDLE: start & !abort & length≠0 -> FETCH; start & !abort & length=0 -> DONE with result <= 0, no reads, no CLK_EN.
- FETCH: both R_EN high every cycle; beat i (0..length-1) reads oper_base+i (mod 2^ADDR_W) and coef_base+(i mod coef_len) (coef_len=0: coef_base+i mod 2^ADDR_W). After beat length-1 -> DRAIN.
- CLK_EN = R_EN delayed one cycle; ACC_CLEAR = high only on the CLK_EN beat of read beat 0.
- DRAIN: 3 cycles (last CLK_EN beat, MATH_BLOCK accumulator->output FF, sample); on 3rd cycle result <= FMATHB_EFPGA_MAC_OUT; -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- abort in FETCH/DRAIN/DONE: -> IDLE next cycle; R_EN, CLK_EN, ACC_CLEAR forced low that cycle onward; done not pulsed; result unchanged.
- start while busy ignored. start & abort in IDLE: stay IDLE.
- R_ADDR holds last value when R_EN low.

## Timing
- Reset: state IDLE; all R_EN, R_ADDR, CLK_EN, ACC_CLEAR, result, done, busy = 0.
- start accepted in cycle 0 (L=length≥1): reads cycles 1..L; CLK_EN cycles 2..L+1; ACC_CLEAR cycle 2; result captured end of cycle L+3; done=1 in cycle L+4; busy cycles 1..L+4; IDLE in L+5 (next start accepted there).
- L=0: done=1 and busy=1 in cycle 1, result=0.
- TPRAM read latency fixed at 1 cycle; MATH_BLOCK output register adds 1 cycle after accumulate.
- Reset mid-pass: same as reset values next cycle, no done.

## Test plan
- Reset: hold reset 3 cycles mid-FETCH -> all outputs 0 next cycle, state IDLE, no done.
- Basic: oper {1,2,3,4} at 0x000, coef {5,6,7,8} at 0x100, L=4, 32-bit mode -> CLK_EN cycles 2-5, ACC_CLEAR cycle 2 only, done cycle 8, result=70.
- Coef ring: coef_base=0x10, coef_len=2, L=5 -> COEF_R_ADDR 0x10,0x11,0x10,0x11,0x10; oper addresses consecutive.
- Operand wrap: oper_base=0x3FE, L=3 -> OPER_R_ADDR 0x3FE,0x3FF,0x000.
- Abort: L=6, abort in cycle 3 -> R_EN/CLK_EN low from cycle 3, no done, result unchanged; new start L=1 -> ACC_CLEAR on its first beat, done 5 cycles later.
- Edge: L=0 -> done cycle 1, result=0, no R_EN; start pulsed during busy pass -> ignored, single done.
